// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and the ignored-code classifier
// for the PS/2 scan-code tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK} parse_state_t;
  typedef enum logic [1:0] {FETCH, POP, GAP} fetch_state_t;

  // BAT, ACK, echo and error bytes carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                    is_ignored = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_code_parser.sv
// Prefix FSM: folds E0/F0 prefixes into a single event that is flagged
// combinationally in the same cycle as the byte that completes it.
module ps2_code_parser
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       i_strobe,
  input  logic [7:0] i_byte,
  output logic       o_ev_valid,
  output logic [7:0] o_ev_code,
  output logic       o_ev_ext,
  output logic       o_ev_break
);

  parse_state_t r_state;
  logic         r_ext;
  logic         w_plain;

  assign w_plain = !is_ignored(i_byte) && (i_byte != PS2_EXT) && (i_byte != PS2_BRK);

  always_comb begin
    o_ev_valid = i_strobe && w_plain;
    o_ev_code  = i_byte;
    o_ev_ext   = r_ext;
    o_ev_break = (r_state == BRK);
  end

  // Any completed event or ignored byte drops back to IDLE with ext cleared.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_ext   <= 1'b0;
    end else if (i_strobe) begin
      case (r_state)
        IDLE: begin
          if (i_byte == PS2_EXT) begin
            r_ext   <= 1'b1;
            r_state <= EXT;
          end else if (i_byte == PS2_BRK) begin
            r_state <= BRK;
          end
        end
        EXT: begin
          if (i_byte == PS2_BRK) begin
            r_state <= BRK;
          end else if (i_byte != PS2_EXT) begin
            r_ext   <= 1'b0;
            r_state <= IDLE;
          end
        end
        BRK: begin
          if ((i_byte != PS2_BRK) && (i_byte != PS2_EXT)) begin
            r_ext   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ext   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops bytes from the ps2_keyboard FIFO, turns them into key events and
// tracks held key, press count and a history of new presses.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               ready,
  input  logic [7:0]         data,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic               ev_valid,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_break,
  output logic               ev_repeat,
  output logic               key_down,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic [CNT_W-1:0]   press_count,
  output logic [DEPTH*9-1:0] hist,
  output logic               lost
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  fetch_state_t       r_fetch;
  logic               r_nextdata_n;
  logic               r_ev_valid, r_ev_ext, r_ev_break, r_ev_repeat;
  logic [7:0]         r_ev_code;
  logic               r_key_down, r_key_ext;
  logic [7:0]         r_key_code;
  logic [CNT_W-1:0]   r_press_count;
  logic [DEPTH*9-1:0] r_hist;
  logic               r_lost;

  logic               w_strobe;
  logic               w_ev_valid, w_ev_ext, w_ev_break;
  logic [7:0]         w_ev_code;
  logic [8:0]         w_key;
  logic               w_same;
  logic [DEPTH*9-1:0] w_hist_next;

  // The FIFO head is consumed on the FETCH edge; the pop strobe follows.
  assign w_strobe = (r_fetch == FETCH) && ready;

  ps2_code_parser u_parser (
    .clk        (clk),
    .clrn       (clrn),
    .i_strobe   (w_strobe),
    .i_byte     (data),
    .o_ev_valid (w_ev_valid),
    .o_ev_code  (w_ev_code),
    .o_ev_ext   (w_ev_ext),
    .o_ev_break (w_ev_break)
  );

  assign w_key  = {w_ev_ext, w_ev_code};
  assign w_same = (w_key == {r_key_ext, r_key_code});

  always_comb begin
    w_hist_next      = r_hist << 9;
    w_hist_next[8:0] = w_key;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_fetch      <= FETCH;
      r_nextdata_n <= 1'b1;
    end else begin
      case (r_fetch)
        FETCH: if (ready) begin
          r_fetch      <= POP;
          r_nextdata_n <= 1'b0;
        end
        POP: begin
          r_fetch      <= GAP;
          r_nextdata_n <= 1'b1;
        end
        default: begin
          r_fetch      <= FETCH;
          r_nextdata_n <= 1'b1;
        end
      endcase
    end
  end

  // A make of the already-held key is a typematic repeat and leaves state alone.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ev_valid    <= 1'b0;
      r_ev_code     <= 8'h00;
      r_ev_ext      <= 1'b0;
      r_ev_break    <= 1'b0;
      r_ev_repeat   <= 1'b0;
      r_key_down    <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_press_count <= '0;
      r_hist        <= '0;
      r_lost        <= 1'b0;
    end else begin
      r_ev_valid <= w_ev_valid;
      if (overflow) r_lost <= 1'b1;
      if (w_ev_valid) begin
        r_ev_code  <= w_ev_code;
        r_ev_ext   <= w_ev_ext;
        r_ev_break <= w_ev_break;
        if (w_ev_break) begin
          r_ev_repeat <= 1'b0;
          if (w_same) r_key_down <= 1'b0;
        end else if (r_key_down && w_same) begin
          r_ev_repeat <= 1'b1;
        end else begin
          r_ev_repeat   <= 1'b0;
          r_key_down    <= 1'b1;
          r_key_code    <= w_ev_code;
          r_key_ext     <= w_ev_ext;
          r_press_count <= r_press_count + CNT_ONE;
          r_hist        <= w_hist_next;
        end
      end
    end
  end

  assign nextdata_n  = r_nextdata_n;
  assign ev_valid    = r_ev_valid;
  assign ev_code     = r_ev_code;
  assign ev_ext      = r_ev_ext;
  assign ev_break    = r_ev_break;
  assign ev_repeat   = r_ev_repeat;
  assign key_down    = r_key_down;
  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign press_count = r_press_count;
  assign hist        = r_hist;
  assign lost        = r_lost;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus random
// byte streams compared against a rule-level model of key events.
module tb_ps2_key_tracker;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        overflow = 1'b0;

  logic        nextdata_n, ev_valid, ev_ext, ev_break, ev_repeat, key_down, key_ext, lost;
  logic [7:0]  ev_code, key_code, press_count;
  logic [26:0] hist;

  logic        b_nextdata_n, b_ev_valid, b_ev_ext, b_ev_break, b_ev_repeat, b_key_down, b_key_ext, b_lost;
  logic [7:0]  b_ev_code, b_key_code;
  logic [1:0]  b_press_count;
  logic [26:0] b_hist;

  ps2_key_tracker #(.DEPTH(3), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_repeat(ev_repeat), .key_down(key_down), .key_code(key_code),
    .key_ext(key_ext), .press_count(press_count), .hist(hist), .lost(lost)
  );

  ps2_key_tracker #(.DEPTH(3), .CNT_W(2)) dut2 (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(b_nextdata_n), .ev_valid(b_ev_valid), .ev_code(b_ev_code), .ev_ext(b_ev_ext),
    .ev_break(b_ev_break), .ev_repeat(b_ev_repeat), .key_down(b_key_down), .key_code(b_key_code),
    .key_ext(b_key_ext), .press_count(b_press_count), .hist(b_hist), .lost(b_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        evValid;
    logic [7:0]  evCode;
    logic        evExt;
    logic        evBreak;
    logic        evRepeat;
    logic        keyDown;
    logic [7:0]  keyCode;
    logic        keyExt;
    logic [7:0]  cnt;
    logic [26:0] hist;
    logic        lost;
    logic [1:0]  cnt2;
  } snap_t;

  int checks = 0;
  int errors = 0;
  int popCount = 0;
  int bytesSent = 0;

  // Reference model state, kept as plain flags, a key id and a history queue.
  bit         mSawExt, mSawBrk;
  bit         mEvValid, mEvExt, mEvBreak, mEvRepeat;
  logic [7:0] mEvCode;
  bit         mKeyDown;
  logic [8:0] mKey;
  int         mCount;
  logic [8:0] mHist[$];
  bit         mLost;

  always @(negedge clk) if (clrn && !nextdata_n) popCount++;

  function automatic bit isIgnoredModel(input logic [7:0] b);
    logic [7:0] lst[8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    foreach (lst[i]) if (lst[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mSawExt = 0; mSawBrk = 0;
    mEvValid = 0; mEvExt = 0; mEvBreak = 0; mEvRepeat = 0; mEvCode = 8'h00;
    mKeyDown = 0; mKey = 9'h000; mCount = 0; mHist.delete(); mLost = 0;
  endtask

  task automatic modelByte(input logic [7:0] b);
    logic [8:0] k;
    mEvValid = 0;
    if (b == 8'hE0) begin
      if (!mSawBrk) mSawExt = 1;
    end else if (b == 8'hF0) begin
      mSawBrk = 1;
    end else if (isIgnoredModel(b)) begin
      mSawExt = 0; mSawBrk = 0;
    end else begin
      k = {mSawExt, b};
      mEvValid = 1; mEvCode = b; mEvExt = mSawExt; mEvBreak = mSawBrk;
      if (mSawBrk) begin
        mEvRepeat = 0;
        if (k == mKey) mKeyDown = 0;
      end else if (mKeyDown && k == mKey) begin
        mEvRepeat = 1;
      end else begin
        mEvRepeat = 0; mKeyDown = 1; mKey = k; mCount++;
        mHist.push_front(k);
        if (mHist.size() > 3) void'(mHist.pop_back());
      end
      mSawExt = 0; mSawBrk = 0;
    end
  endtask

  function automatic snap_t expected();
    snap_t e;
    e.evValid = mEvValid; e.evCode = mEvCode; e.evExt = mEvExt;
    e.evBreak = mEvBreak; e.evRepeat = mEvRepeat; e.keyDown = mKeyDown;
    e.keyCode = mKey[7:0]; e.keyExt = mKey[8];
    e.cnt = 8'(mCount % 256);
    e.hist = '0;
    for (int i = 0; i < 3; i++) if (i < mHist.size()) e.hist[9*i +: 9] = mHist[i];
    e.lost = mLost;
    e.cnt2 = 2'(mCount % 4);
    return e;
  endfunction

  function automatic snap_t observe();
    snap_t o;
    o.evValid = ev_valid; o.evCode = ev_code; o.evExt = ev_ext;
    o.evBreak = ev_break; o.evRepeat = ev_repeat; o.keyDown = key_down;
    o.keyCode = key_code; o.keyExt = key_ext; o.cnt = press_count;
    o.hist = hist; o.lost = lost; o.cnt2 = b_press_count;
    return o;
  endfunction

  // Presents one byte while in FETCH and captures outputs in the pop cycle.
  task automatic applyStimulus(input logic [7:0] b, output snap_t obs, output bit ok);
    ok = 0;
    @(negedge clk);
    ready = 1'b1;
    data  = b;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (nextdata_n === 1'b0) begin
        ok = 1;
        break;
      end
    end
    obs = observe();
    ready = 1'b0;
    modelByte(b);
    bytesSent++;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    clrn = 1'b0; ready = 1'b0; overflow = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_make_break();
    logic [7:0] seq[$];
    snap_t obs;
    bit ok;
    int pops0;
    doReset();
    pops0 = popCount;
    seq = '{8'h1C, 8'hF0, 8'h1C};
    foreach (seq[i]) begin
      applyStimulus(seq[i], obs, ok);
      checks++;
      if (!ok || obs !== expected()) begin
        errors++;
        $display("[TB] FAIL make_break byte%0d: got %h need %h (popped=%0d)", i, obs, expected(), ok);
      end
      if (i == 0) begin
        checks++;
        if ({obs.evValid, obs.keyDown, obs.cnt, obs.hist[8:0]} !== {1'b1, 1'b1, 8'd1, 9'h01C}) begin
          errors++;
          $display("[TB] FAIL make_first: got v=%b kd=%b cnt=%0d h0=%h", obs.evValid, obs.keyDown, obs.cnt, obs.hist[8:0]);
        end
      end
    end
    checks++;
    if ({obs.evBreak, obs.keyDown} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL break_release: got brk=%b kd=%b need 1 0", obs.evBreak, obs.keyDown);
    end
    checks++;
    if (popCount - pops0 !== 3) begin
      errors++;
      $display("[TB] FAIL pop_count: got %0d need 3", popCount - pops0);
    end
  endtask

  task automatic test_repeat();
    logic [7:0] seq[$];
    logic [2:0] reps;
    snap_t obs;
    bit ok;
    doReset();
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    foreach (seq[i]) begin
      applyStimulus(seq[i], obs, ok);
      if (i < 3) reps[i] = obs.evRepeat;
      checks++;
      if (!ok || obs !== expected()) begin
        errors++;
        $display("[TB] FAIL repeat byte%0d: got %h need %h", i, obs, expected());
      end
    end
    checks++;
    if ({reps, obs.cnt, obs.hist, obs.keyDown} !== {3'b110, 8'd1, 27'h000001C, 1'b0}) begin
      errors++;
      $display("[TB] FAIL repeat_flags: got reps=%b cnt=%0d hist=%h kd=%b", reps, obs.cnt, obs.hist, obs.keyDown);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq[$];
    snap_t obs;
    bit ok;
    doReset();
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) begin
      applyStimulus(seq[i], obs, ok);
      checks++;
      if (!ok || obs !== expected()) begin
        errors++;
        $display("[TB] FAIL extended byte%0d: got %h need %h", i, obs, expected());
      end
      if (i == 1) begin
        checks++;
        if ({obs.evExt, obs.hist[8:0]} !== {1'b1, 9'h175}) begin
          errors++;
          $display("[TB] FAIL ext_make: got ext=%b h0=%h need 1 175", obs.evExt, obs.hist[8:0]);
        end
      end
    end
    checks++;
    if ({obs.evExt, obs.evBreak, obs.keyDown} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL ext_break: got ext=%b brk=%b kd=%b need 1 1 0", obs.evExt, obs.evBreak, obs.keyDown);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] seq[$];
    snap_t obs;
    bit ok;
    doReset();
    seq = '{8'hE0, 8'hAA, 8'h1C, 8'hF0, 8'h32};
    foreach (seq[i]) begin
      applyStimulus(seq[i], obs, ok);
      checks++;
      if (!ok || obs !== expected()) begin
        errors++;
        $display("[TB] FAIL ignored byte%0d: got %h need %h", i, obs, expected());
      end
      if (i == 2) begin
        checks++;
        if ({obs.evValid, obs.evExt, obs.evCode} !== {1'b1, 1'b0, 8'h1C}) begin
          errors++;
          $display("[TB] FAIL ignored_clears_ext: got v=%b ext=%b code=%h", obs.evValid, obs.evExt, obs.evCode);
        end
      end
    end
    checks++;
    if ({obs.evBreak, obs.evCode, obs.keyDown, obs.keyCode} !== {1'b1, 8'h32, 1'b1, 8'h1C}) begin
      errors++;
      $display("[TB] FAIL other_break: got brk=%b code=%h kd=%b key=%h", obs.evBreak, obs.evCode, obs.keyDown, obs.keyCode);
    end
  endtask

  task automatic test_reset();
    snap_t obs;
    @(posedge clk);
    #2;
    clrn = 1'b0;
    ready = 1'b0;
    #1;
    obs = observe();
    modelReset();
    checks++;
    if (obs !== expected() || nextdata_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h nd=%b need %h nd=1", obs, nextdata_n, expected());
    end
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_history_wrap();
    logic [7:0] seq[$];
    snap_t obs;
    bit ok;
    doReset();
    seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h1C};
    foreach (seq[i]) begin
      applyStimulus(seq[i], obs, ok);
      checks++;
      if (!ok || obs !== expected()) begin
        errors++;
        $display("[TB] FAIL history byte%0d: got %h need %h", i, obs, expected());
      end
      if (i == 3) begin
        checks++;
        if (obs.hist !== {9'h01D, 9'h024, 9'h02D}) begin
          errors++;
          $display("[TB] FAIL hist_drop: got %h need %h", obs.hist, {9'h01D, 9'h024, 9'h02D});
        end
      end
    end
    checks++;
    if (obs.cnt2 !== 2'd1 || obs.cnt !== 8'd5) begin
      errors++;
      $display("[TB] FAIL count_wrap: got cnt2=%0d cnt=%0d need 1 5", obs.cnt2, obs.cnt);
    end
  endtask

  task automatic test_reset_midseq();
    snap_t obs;
    bit ok;
    doReset();
    applyStimulus(8'hF0, obs, ok);
    doReset();
    applyStimulus(8'h1C, obs, ok);
    checks++;
    if (!ok || obs !== expected() || obs.evBreak !== 1'b0 || obs.keyDown !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_forgets_f0: got %h need %h", obs, expected());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] seq[$];
    snap_t obs;
    bit ok;
    doReset();
    applyStimulus(8'h1C, obs, ok);
    checks++;
    if (!ok || obs !== expected() || obs.lost !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lost_before: got %h need %h", obs, expected());
    end
    @(negedge clk);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    mLost = 1;
    seq = '{8'h1D, 8'hF0, 8'h1D};
    foreach (seq[i]) begin
      applyStimulus(seq[i], obs, ok);
      checks++;
      if (!ok || obs !== expected() || obs.lost !== 1'b1) begin
        errors++;
        $display("[TB] FAIL lost_sticky byte%0d: got %h need %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    snap_t obs;
    n = 0;
    @(negedge clk);
    ready = 1'b1;
    data  = 8'hFA;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (nextdata_n === 1'b0) n++;
    end
    ready = 1'b0;
    repeat (3) modelByte(8'hFA);
    bytesSent += 3;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("[TB] FAIL held_ready_pops: got %0d need 3", n);
    end
    obs = observe();
    mEvValid = 0;
    checks++;
    if (obs !== expected()) begin
      errors++;
      $display("[TB] FAIL held_ready_state: got %h need %h", obs, expected());
    end
  endtask

  task automatic test_random();
    logic [7:0] codes[5] = '{8'h1C, 8'h1D, 8'h75, 8'h32, 8'h15};
    logic [7:0] ign[4] = '{8'hAA, 8'hFA, 8'h00, 8'hEE};
    logic [7:0] b;
    snap_t obs;
    bit ok;
    int r;
    doReset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else if (r == 4) b = ign[$urandom_range(0, 3)];
      else             b = codes[$urandom_range(0, 4)];
      applyStimulus(b, obs, ok);
      checks++;
      if (!ok || obs !== expected()) begin
        errors++;
        $display("[TB] FAIL random step%0d byte=%h: got %h need %h", i, b, obs, expected());
      end
    end
  endtask

  initial begin
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    test_make_break();
    test_repeat();
    test_extended();
    test_ignored();
    test_reset();
    test_history_wrap();
    test_reset_midseq();
    test_overflow();
    test_back_to_back();
    test_random();
    checks++;
    if (popCount !== bytesSent) begin
      errors++;
      $display("[TB] FAIL pop_total: got %0d need %0d", popCount, bytesSent);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Consumes scan-code bytes from the existing ps2_keyboard FIFO through its ready/nextdata_n handshake. Parses PS/2 set-2 prefixes (E0 extended, F0 break) into complete key events, and suppresses typematic repeats. Tracks the currently held key, a wrapping press counter and a DEPTH-entry history of new presses. Sits between ps2_keyboard and the display/ASCII logic in the keyboard top.

Parameters:
DEPTH, 3, number of history entries of new key presses (>=1)
CNT_W, 8, width of press counter

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
ready  in  1  ps2_keyboard FIFO non-empty; data valid
data  in  8  ps2_keyboard FIFO head byte
overflow  in  1  ps2_keyboard FIFO overflow flag
nextdata_n  out  1  active-low pop strobe to ps2_keyboard
ev_valid  out  1  one-cycle pulse: key event completed
ev_code  out  8  event scan code (without prefixes)
ev_ext  out  1  event had E0 prefix
ev_break  out  1  event is a release
ev_repeat  out  1  event is a typematic repeat make
key_down  out  1  a key is currently held
key_code  out  8  current/last pressed code
key_ext  out  1  current/last pressed key extended
press_count  out  CNT_W  count of new presses, wraps
hist  out  DEPTH*9  history, entry i = hist[9i+8:9i] = {ext,code}, entry 0 newest
lost  out  1  sticky: overflow seen

Behaviour:
- Reset (clrn=0, async): nextdata_n=1, all other outputs 0, parser IDLE, fetch FETCH, hist all 0.
- Fetch FSM: FETCH -> on ready=1 latch data, go POP. POP: nextdata_n=0 for exactly this one cycle, go GAP. GAP: nextdata_n=1, ready ignored, go FETCH. Max 1 byte per 3 cycles; never pops while ready=0.
- Byte latched in cycle N is processed in N+1 (same cycle as nextdata_n=0). Event outputs are registered and visible in cycle N+1. ev_* fields hold their values until the next event; ev_valid is high in N+1 only.
- Parser FSM, ext flag held in a register:
  - IDLE: E0 -> ext=1, go EXT. F0 -> go BRK. Ignored code -> stay. Other -> make event (ext=0).
  - EXT: F0 -> go BRK (ext kept). E0 -> stay. Ignored code -> ext=0, go IDLE. Other -> make event (ext=1), go IDLE.
  - BRK: F0/E0 -> stay. Ignored code -> ext=0, go IDLE. Other -> break event (ext as held), ext=0, go IDLE.
  - Ignored codes: 00, AA, EE, FA, FC, FD, FE, FF (BAT/ACK/echo/error). E1 (Pause) is unsupported and treated as an ordinary code.
- Make event:
  - If key_down=1 and {ext,code}=={key_ext,key_code}: repeat. ev_repeat=1; no count change, no history push.
  - Else new press: key_down=1, key_code/key_ext updated, press_count+1 (2^CNT_W-1 -> 0), hist shifts (entry i <- i-1, entry 0 <- {ext,code}, oldest dropped), ev_repeat=0.
- Break event: ev_break=1. If {ext,code} matches the current key, key_down=0; otherwise key state is unchanged. key_code/key_ext retain the last pressed value.
- lost: set when overflow=1 in any cycle; cleared only by reset. Parsing continues regardless.
- Reset mid-sequence discards partial prefixes (e.g. a held F0 is forgotten).

Decomposition:
- Package ps2_pkg: constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, ignored-code list/function is_ignored(byte), parser state enum {IDLE,EXT,BRK}, fetch state enum {FETCH,POP,GAP}.
- One sub-module, ps2_code_parser: byte in plus strobe -> event fields plus ev_valid, prefix FSM only. Key state, counter, history and handshake stay in ps2_key_tracker.

Test Plan:
- Feed 1C, F0, 1C -> make ev {ext0,1C}, press_count=1, key_down=1, hist[8:0]=01C; then break ev, key_down=0; nextdata_n low exactly 3 single cycles.
- Feed 1C, 1C, 1C, F0, 1C -> 3 makes with ev_repeat=0,1,1; press_count=1; one hist entry; final key_down=0.
- Feed E0, 75, E0, F0, 75 -> make {ext1,75}, hist[8:0]=175; break ev_ext=1 ev_break=1, key_down=0.
- Feed E0, AA, 1C -> AA ignored, ext cleared, make ev_ext=0 code 1C. Feed F0, 32 while 1C held -> break ev for 32, key_down stays 1.
- DEPTH=3: presses 15, 1D, 24, 2D -> hist = {02D,024,01D} (entry0..2), 15 dropped. CNT_W=2 with 5 presses -> press_count=1.
- Feed F0, assert clrn=0 for 2 cycles, then feed 1C -> make event (not break). Pulse overflow=1 -> lost=1 until next reset. With ready held high for 9 cycles -> exactly 3 pops.
